// File: rtl/hist_mem_arbiter_pkg.sv
// Shared definitions for the histogram/CDF SRAM arbiter: requester ids and default geometry.
package hist_mem_arbiter_pkg;

   localparam int NUM_REQ           = 3;
   localparam int DEF_ADDR_W        = 8;
   localparam int DEF_DATA_W        = 20;
   localparam int DEF_MAX_BURST     = 16;

   typedef enum logic [1:0] {
      REQ_IN   = 2'd0,
      REQ_CDF  = 2'd1,
      REQ_OUT  = 2'd2,
      REQ_NONE = 2'd3
   } req_id_t;

   function automatic logic [NUM_REQ-1:0] req_onehot(input req_id_t id);
      logic [NUM_REQ-1:0] v;
      v = '0;
      case (id)
         REQ_IN:  v = 3'b001;
         REQ_CDF: v = 3'b010;
         REQ_OUT: v = 3'b100;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/hist_mem_arbiter_rr_pick3.sv
// Combinational round-robin selector: first requester after 'last' in IN -> CDF -> OUT order.
module rr_pick3
   import hist_mem_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            last,
   output req_id_t            next,
   output logic               valid
);

   req_id_t order [NUM_REQ];

   always_comb begin
      case (last)
         REQ_IN:  order = '{REQ_CDF, REQ_OUT, REQ_IN};
         REQ_CDF: order = '{REQ_OUT, REQ_IN, REQ_CDF};
         default: order = '{REQ_IN, REQ_CDF, REQ_OUT};
      endcase
      next  = REQ_NONE;
      valid = 1'b0;
      // walk backwards so the highest-priority hit is written last
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[order[i]]) begin
            next  = order[i];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hist_mem_arbiter.sv
// Round-robin, burst-capped owner of the shared two-bank histogram/CDF SRAM.
//   state        | meaning
//   owner = NONE | idle, no grant, SRAM disabled
//   owner = X    | stage X holds the grant; accesses issue while X_req is high
module hist_mem_arbiter
   import hist_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_req,
   input  logic              cdf_req,
   input  logic              out_req,
   input  logic              in_we,
   input  logic              cdf_we,
   input  logic              out_we,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [ADDR_W-1:0] cdf_addr,
   input  logic [ADDR_W-1:0] out_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [DATA_W-1:0] cdf_wdata,
   input  logic [DATA_W-1:0] out_wdata,
   input  logic              in_bank,
   input  logic              cdf_bank,
   input  logic              out_bank,
   output logic              in_gnt,
   output logic              cdf_gnt,
   output logic              out_gnt,
   output logic              in_rvalid,
   output logic              cdf_rvalid,
   output logic              out_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W:0]   mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CAP   = CNT_W'(MAX_BURST - 1);

   req_id_t            owner;
   req_id_t            last_owner;
   req_id_t            pick_base;
   req_id_t            pick;
   logic               pick_valid;
   logic [CNT_W-1:0]   burst_cnt;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] rvalid_q;
   logic [NUM_REQ-1:0] reqv;
   logic               access;
   logic               others_wait;
   logic               retain;

   assign reqv        = {out_req, cdf_req, in_req};
   assign access      = |(gnt & reqv);
   assign others_wait = |(reqv & ~gnt);
   assign retain      = access && ((burst_cnt < CAP) || !others_wait);

   // a releasing owner rotates from itself; idle rotates from the previous owner
   assign pick_base = (owner == REQ_NONE) ? last_owner : owner;

   rr_pick3 u_pick (
      .req   (reqv),
      .last  (pick_base),
      .next  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      mem_en    = access;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (owner)
         REQ_IN: begin
            mem_we    = access & in_we;
            mem_addr  = {in_bank, in_addr};
            mem_wdata = in_wdata;
         end
         REQ_CDF: begin
            mem_we    = access & cdf_we;
            mem_addr  = {cdf_bank, cdf_addr};
            mem_wdata = cdf_wdata;
         end
         REQ_OUT: begin
            mem_we    = access & out_we;
            mem_addr  = {out_bank, out_addr};
            mem_wdata = out_wdata;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner      <= REQ_NONE;
         last_owner <= REQ_OUT;
         gnt        <= '0;
         burst_cnt  <= '0;
         rvalid_q   <= '0;
      end else begin
         rvalid_q <= (access && !mem_we) ? gnt : '0;
         if (retain) begin
            burst_cnt <= (burst_cnt == CAP) ? '0 : burst_cnt + CNT_W'(1);
         end else begin
            burst_cnt <= '0;
            if (owner != REQ_NONE) begin
               last_owner <= owner;
            end
            owner <= pick_valid ? pick : REQ_NONE;
            gnt   <= pick_valid ? req_onehot(pick) : '0;
         end
      end
   end

   assign in_gnt     = gnt[REQ_IN];
   assign cdf_gnt    = gnt[REQ_CDF];
   assign out_gnt    = gnt[REQ_OUT];
   assign in_rvalid  = rvalid_q[REQ_IN];
   assign cdf_rvalid = rvalid_q[REQ_CDF];
   assign out_rvalid = rvalid_q[REQ_OUT];
   assign rdata      = mem_rdata;

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// Bench for hist_mem_arbiter: per-cycle vector table plus hand-written burst, RMW and reset sequences.
module tb_hist_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_req, cdf_req, out_req;
   logic        in_we, cdf_we, out_we;
   logic [7:0]  in_addr, cdf_addr, out_addr;
   logic [19:0] in_wdata, cdf_wdata, out_wdata;
   logic        in_bank, cdf_bank, out_bank;
   logic        in_gnt, cdf_gnt, out_gnt;
   logic        in_rvalid, cdf_rvalid, out_rvalid;
   logic [19:0] rdata;
   logic        mem_en, mem_we;
   logic [8:0]  mem_addr;
   logic [19:0] mem_wdata;
   logic [19:0] mem_rdata;

   logic        preload;
   logic [19:0] sram [512];

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   hist_mem_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .in_req     (in_req),
      .cdf_req    (cdf_req),
      .out_req    (out_req),
      .in_we      (in_we),
      .cdf_we     (cdf_we),
      .out_we     (out_we),
      .in_addr    (in_addr),
      .cdf_addr   (cdf_addr),
      .out_addr   (out_addr),
      .in_wdata   (in_wdata),
      .cdf_wdata  (cdf_wdata),
      .out_wdata  (out_wdata),
      .in_bank    (in_bank),
      .cdf_bank   (cdf_bank),
      .out_bank   (out_bank),
      .in_gnt     (in_gnt),
      .cdf_gnt    (cdf_gnt),
      .out_gnt    (out_gnt),
      .in_rvalid  (in_rvalid),
      .cdf_rvalid (cdf_rvalid),
      .out_rvalid (out_rvalid),
      .rdata      (rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // single-port synchronous SRAM model, one-cycle read latency
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) sram[i] <= '0;
         sram[9'h105] <= 20'd1234;
         sram[9'h005] <= 20'd42;
         sram[9'h010] <= 20'd7;
         sram[9'h030] <= 20'd300;
         sram[9'h130] <= 20'd555;
      end else if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= sram[mem_addr];
      end
   end

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  we;
      logic [2:0]  bank;
      logic [2:0]  exp_gnt;
      logic        exp_en;
      logic        exp_we;
      logic [8:0]  exp_maddr;
      logic [2:0]  exp_rvalid;
      logic [19:0] exp_rdata;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [2:0] we,
                               input logic [2:0] bank, input logic [2:0] gnt, input logic en,
                               input logic mwe, input logic [8:0] maddr, input logic [2:0] rv,
                               input logic [19:0] rd);
      vec_t v;
      v.rst = rst; v.req = req; v.we = we; v.bank = bank; v.exp_gnt = gnt;
      v.exp_en = en; v.exp_we = mwe; v.exp_maddr = maddr; v.exp_rvalid = rv; v.exp_rdata = rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      in_req = 0; cdf_req = 0; out_req = 0;
      in_we = 0; cdf_we = 0; out_we = 0;
      in_addr = 8'h10; cdf_addr = 8'h05; out_addr = 8'h30;
      in_wdata = 20'd0; cdf_wdata = 20'd0; out_wdata = 20'd0;
      in_bank = 0; cdf_bank = 0; out_bank = 0;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      set_idle();
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int in_acc, out_acc, run1, onehot_err, pulses;
      logic seen_out, regrant, handoff_ok, got;
      logic [2:0] prev_gnt, gnow;

      // rst, req, we, bank, gnt, en, we, maddr, rvalid, rdata  (bit order {out,cdf,in})
      vecs[0]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);
      vecs[1]  = mk(0, 3'b010, 3'b000, 3'b010, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);
      vecs[2]  = mk(0, 3'b010, 3'b000, 3'b010, 3'b010, 1, 0, 9'h105, 3'b000, 20'd0);
      vecs[3]  = mk(0, 3'b000, 3'b000, 3'b010, 3'b010, 0, 0, 9'h000, 3'b010, 20'd1234);
      vecs[4]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);
      vecs[5]  = mk(1, 3'b111, 3'b000, 3'b000, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);
      vecs[6]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);
      vecs[7]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b001, 1, 0, 9'h010, 3'b000, 20'd0);
      vecs[8]  = mk(0, 3'b011, 3'b000, 3'b000, 3'b001, 1, 0, 9'h010, 3'b001, 20'd7);
      vecs[9]  = mk(0, 3'b110, 3'b000, 3'b000, 3'b001, 0, 0, 9'h000, 3'b001, 20'd7);
      vecs[10] = mk(0, 3'b110, 3'b000, 3'b000, 3'b010, 1, 0, 9'h005, 3'b000, 20'd0);
      vecs[11] = mk(0, 3'b100, 3'b000, 3'b000, 3'b010, 0, 0, 9'h000, 3'b010, 20'd42);
      vecs[12] = mk(0, 3'b100, 3'b000, 3'b100, 3'b100, 1, 0, 9'h130, 3'b000, 20'd0);
      vecs[13] = mk(0, 3'b000, 3'b000, 3'b000, 3'b100, 0, 0, 9'h000, 3'b100, 20'd555);
      vecs[14] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 9'h000, 3'b000, 20'd0);

      set_idle();
      reset   = 1;
      preload = 1;
      repeat (2) @(posedge clock);
      #1;
      reset   = 0;
      preload = 0;

      for (int i = 0; i < 15; i++) begin
         @(posedge clock); #1;
         reset = vecs[i].rst;
         {out_req, cdf_req, in_req}    = vecs[i].req;
         {out_we, cdf_we, in_we}       = vecs[i].we;
         {out_bank, cdf_bank, in_bank} = vecs[i].bank;
         @(negedge clock);
         check($sformatf("v%0d_gnt", i), {29'd0, out_gnt, cdf_gnt, in_gnt}, {29'd0, vecs[i].exp_gnt});
         check($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].exp_en});
         check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_we});
         check($sformatf("v%0d_rvalid", i), {29'd0, out_rvalid, cdf_rvalid, in_rvalid},
               {29'd0, vecs[i].exp_rvalid});
         if (vecs[i].exp_en) check($sformatf("v%0d_mem_addr", i), {23'd0, mem_addr}, {23'd0, vecs[i].exp_maddr});
         if (vecs[i].exp_rvalid != 3'b000) check($sformatf("v%0d_rdata", i), {12'd0, rdata}, {12'd0, vecs[i].exp_rdata});
      end
      reset = 0;

      // burst cap with OUT waiting from the first cycle
      do_reset();
      in_acc = 0; out_acc = 0; run1 = -1; onehot_err = 0;
      seen_out = 0; regrant = 0; handoff_ok = 0; prev_gnt = 3'b000;
      for (int cyc = 0; cyc < 300 && !(in_acc >= 40 && out_acc >= 3); cyc++) begin
         @(posedge clock); #1;
         in_req  = (in_acc < 40);
         out_req = (out_acc < 3);
         @(negedge clock);
         gnow = {out_gnt, cdf_gnt, in_gnt};
         if (gnow != 3'b000 && !$onehot(gnow)) onehot_err++;
         if (out_gnt && !seen_out) begin
            seen_out   = 1;
            run1       = in_acc;
            handoff_ok = (prev_gnt == 3'b001);
         end
         if (seen_out && in_gnt) regrant = 1;
         if (in_gnt && mem_en) in_acc++;
         if (out_gnt && mem_en) out_acc++;
         prev_gnt = gnow;
      end
      check("cap_first_run", run1, 16);
      check("cap_handoff_no_gap", {31'd0, handoff_ok}, 1);
      check("cap_in_total", in_acc, 40);
      check("cap_out_total", out_acc, 3);
      check("cap_in_regranted", {31'd0, regrant}, 1);
      check("cap_onehot", onehot_err, 0);

      // cap reached with nobody else waiting: no gaps
      do_reset();
      @(posedge clock); #1;
      in_req = 1;
      @(posedge clock);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (in_gnt && mem_en) pulses++;
         @(posedge clock);
      end
      #1;
      in_req = 0;
      check("solo_pulses", pulses, 40);

      // read-modify-write by IN, then CDF reads back the new value
      @(posedge clock); #1;
      preload = 1;
      @(posedge clock); #1;
      preload = 0;
      set_idle();
      in_req = 1;
      @(posedge clock); #1;
      @(negedge clock);
      check("rmw_read_issue", {30'd0, in_gnt, mem_en}, 32'h3);
      @(posedge clock); #1;
      in_we    = 1;
      in_wdata = rdata + 20'd1;
      @(negedge clock);
      check("rmw_in_rvalid", {31'd0, in_rvalid}, 1);
      check("rmw_rdata", {12'd0, rdata}, 7);
      check("rmw_write_issue", {30'd0, mem_en, mem_we}, 32'h3);
      @(posedge clock); #1;
      in_req = 0; in_we = 0;
      cdf_req = 1; cdf_addr = 8'h10; cdf_bank = 0;
      check("rmw_sram_value", {12'd0, sram[9'h010]}, 8);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clock);
         if (cdf_rvalid) begin
            got = 1;
            check("rmw_cdf_rdata", {12'd0, rdata}, 8);
            check("rmw_other_rvalid", {30'd0, out_rvalid, in_rvalid}, 0);
         end
         @(posedge clock); #1;
      end
      check("rmw_cdf_rvalid_seen", {31'd0, got}, 1);
      set_idle();

      // reset during an OUT read burst
      do_reset();
      out_req = 1;
      @(posedge clock); #1;
      @(negedge clock);
      check("rst_out_owned", {29'd0, out_gnt, cdf_gnt, in_gnt}, 32'h4);
      @(posedge clock); #1;
      reset = 1;
      @(negedge clock);
      check("rst_read_in_flight", {31'd0, out_rvalid}, 1);
      @(posedge clock); #1;
      reset = 0;
      {out_req, cdf_req, in_req} = 3'b111;
      @(negedge clock);
      check("rst_gnt_cleared", {29'd0, out_gnt, cdf_gnt, in_gnt}, 0);
      check("rst_rvalid_dropped", {29'd0, out_rvalid, cdf_rvalid, in_rvalid}, 0);
      check("rst_mem_en", {31'd0, mem_en}, 0);
      @(posedge clock); #1;
      @(negedge clock);
      check("rst_in_first", {29'd0, out_gnt, cdf_gnt, in_gnt}, 32'h1);
      set_idle();
      repeat (2) @(posedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
